// File: rtl/snake_match_ctrl.sv
// -----------------------------------------------------------------------------
// snake_match_ctrl
//
// Match controller for an N-player snake game. It produces the per-player move
// strobes at a selectable speed, resolves deaths (wall, self-body, other body
// and head-to-head), runs the IDLE/RUN/FLASH/OVER round sequence and keeps the
// per-player scores together with winner detection.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   start        one-cycle pulse: begin a round (IDLE) or a new match (OVER)
//   speed_sel    requested speed level; taken only at a period boundary
//   head_x/y     packed head coordinates, player 0 in the LSBs
//   hit_wall     per-player wall collision (level)
//   hit_body     per-player self-body collision (level)
//   hit_other    per-player collision with another snake's body (level)
//   step         one-cycle move strobe for every alive player
//   alive        players still in the current round
//   game_status  00 IDLE, 01 RUN, 10 FLASH, 11 OVER
//   die_flash    blink signal for the renderer during FLASH
//   score        packed per-player scores, player 0 in the LSBs
//   winner       one-hot match winner, valid in OVER
//   over         high while in OVER
//   speed_light  one-hot of the speed level actually in use
// -----------------------------------------------------------------------------
module snake_match_ctrl #(
  parameter int N_PLAYERS    = 2,
  parameter int COORD_W      = 6,
  parameter int TICK_BASE    = 12500000,
  parameter int SPEED_LEVELS = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 5,
  parameter int FLASH_CYCLES = 50000000,
  parameter int FLASH_TOGGLE = 6250000,
  localparam int SEL_W       = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SEL_W-1:0]               speed_sel,
  input  logic [N_PLAYERS*COORD_W-1:0]   head_x,
  input  logic [N_PLAYERS*COORD_W-1:0]   head_y,
  input  logic [N_PLAYERS-1:0]           hit_wall,
  input  logic [N_PLAYERS-1:0]           hit_body,
  input  logic [N_PLAYERS-1:0]           hit_other,
  output logic [N_PLAYERS-1:0]           step,
  output logic [N_PLAYERS-1:0]           alive,
  output logic [1:0]                     game_status,
  output logic                           die_flash,
  output logic [N_PLAYERS*SCORE_W-1:0]   score,
  output logic [N_PLAYERS-1:0]           winner,
  output logic                           over,
  output logic [SPEED_LEVELS-1:0]        speed_light
);

  localparam int CNT_W = $clog2(TICK_BASE + 1);
  localparam int FC_W  = $clog2(FLASH_CYCLES + 1);
  localparam int FT_W  = $clog2(FLASH_TOGGLE + 1);
  // A multi-player round ends with one survivor; a solo round ends at zero.
  localparam int SURV_MAX = (N_PLAYERS > 1) ? 1 : 0;
  localparam logic [SCORE_W:0] WIN_TH = (SCORE_W + 1)'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLASH = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t                state;
  logic [SEL_W-1:0]      level;
  logic [CNT_W-1:0]      tick_cnt;
  logic [FC_W-1:0]       flash_cnt;
  logic [FT_W-1:0]       toggle_cnt;

  logic [N_PLAYERS-1:0]  hit_any;
  logic [N_PLAYERS-1:0]  dead;
  logic [N_PLAYERS-1:0]  alive_nxt;
  logic [2:0]            alive_cnt;
  logic                  round_end;
  logic                  tick;
  logic [CNT_W-1:0]      period_m1;
  logic [SEL_W-1:0]      sel_sat;
  logic                  win_any;
  logic [N_PLAYERS-1:0]  win_oh;

  // Out-of-range requests clamp to the fastest level.
  function automatic logic [SEL_W-1:0] sat_level(input logic [SEL_W-1:0] sel);
    if (int'(sel) > SPEED_LEVELS - 1)
      return SEL_W'(SPEED_LEVELS - 1);
    return sel;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  function automatic logic [2:0] popcnt(input logic [N_PLAYERS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < N_PLAYERS; k++)
      c = c + {2'b00, v[k]};
    return c;
  endfunction

  function automatic logic [SPEED_LEVELS-1:0] level_onehot(input logic [SEL_W-1:0] lvl);
    logic [SPEED_LEVELS-1:0] v;
    v = '0;
    for (int k = 0; k < SPEED_LEVELS; k++)
      if (int'(lvl) == k) v[k] = 1'b1;
    return v;
  endfunction

  assign game_status = state;

  always_comb begin
    hit_any = hit_wall | hit_body | hit_other;
    dead    = '0;
    // Only alive players can die or kill; a head meeting another alive head
    // marks this player, and the symmetric pass of the loop marks the other.
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (alive[i]) begin
        if (hit_any[i]) dead[i] = 1'b1;
        for (int j = 0; j < N_PLAYERS; j++) begin
          if (j != i && alive[j] &&
              head_x[i*COORD_W +: COORD_W] == head_x[j*COORD_W +: COORD_W] &&
              head_y[i*COORD_W +: COORD_W] == head_y[j*COORD_W +: COORD_W])
            dead[i] = 1'b1;
        end
      end
    end
    alive_nxt = alive & ~dead;
    alive_cnt = popcnt(alive_nxt);
    round_end = (alive_cnt <= 3'(SURV_MAX));

    period_m1 = CNT_W'((TICK_BASE >> level) - 1);
    tick      = (tick_cnt == period_m1);
    sel_sat   = sat_level(speed_sel);

    // Lowest-index player that has reached the winning score.
    win_any = 1'b0;
    win_oh  = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!win_any && ({1'b0, score[i*SCORE_W +: SCORE_W]} >= WIN_TH)) begin
        win_any   = 1'b1;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      step        <= '0;
      alive       <= '1;
      die_flash   <= 1'b0;
      score       <= '0;
      winner      <= '0;
      over        <= 1'b0;
      level       <= '0;
      speed_light <= level_onehot('0);
      tick_cnt    <= '0;
      flash_cnt   <= '0;
      toggle_cnt  <= '0;
    end else begin
      step <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            tick_cnt    <= '0;
            alive       <= '1;
            level       <= sel_sat;
            speed_light <= level_onehot(sel_sat);
          end
        end

        S_RUN: begin
          alive <= alive_nxt;
          if (round_end) begin
            // Round over: step stays low, a sole survivor scores.
            state      <= S_FLASH;
            tick_cnt   <= '0;
            flash_cnt  <= '0;
            toggle_cnt <= '0;
            die_flash  <= 1'b1;
            if (N_PLAYERS > 1 && alive_cnt == 3'd1) begin
              for (int i = 0; i < N_PLAYERS; i++)
                if (alive_nxt[i])
                  score[i*SCORE_W +: SCORE_W] <= sat_inc(score[i*SCORE_W +: SCORE_W]);
            end
          end else if (tick) begin
            // Period boundary: the only point where a new speed is taken.
            tick_cnt    <= '0;
            step        <= alive_nxt;
            level       <= sel_sat;
            speed_light <= level_onehot(sel_sat);
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_FLASH: begin
          if (flash_cnt == FC_W'(FLASH_CYCLES - 1)) begin
            die_flash  <= 1'b0;
            flash_cnt  <= '0;
            toggle_cnt <= '0;
            if (win_any || N_PLAYERS == 1) begin
              state  <= S_OVER;
              over   <= 1'b1;
              winner <= (N_PLAYERS == 1) ? '0 : win_oh;
            end else begin
              state <= S_IDLE;
              alive <= '1;
            end
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
            if (toggle_cnt == FT_W'(FLASH_TOGGLE - 1)) begin
              toggle_cnt <= '0;
              die_flash  <= ~die_flash;
            end else begin
              toggle_cnt <= toggle_cnt + 1'b1;
            end
          end
        end

        S_OVER: begin
          if (start) begin
            // New match starts straight into a round.
            state       <= S_RUN;
            score       <= '0;
            winner      <= '0;
            over        <= 1'b0;
            alive       <= '1;
            tick_cnt    <= '0;
            level       <= sel_sat;
            speed_light <= level_onehot(sel_sat);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_match_ctrl.sv
module tb_snake_match_ctrl;

  localparam int N   = 2;
  localparam int CW  = 6;
  localparam int SW  = 4;
  localparam int SL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      speed_sel;
  logic [N*CW-1:0] head_x, head_y;
  logic [N-1:0]    hit_wall, hit_body, hit_other;
  logic [N-1:0]    step, alive, winner;
  logic [1:0]      game_status;
  logic            die_flash, over;
  logic [N*SW-1:0] score;
  logic [SL-1:0]   speed_light;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Scoreboard of expected step pulses: absolute cycle and value.
  int         exp_cyc[$];
  logic [1:0] exp_val[$];

  snake_match_ctrl #(
    .N_PLAYERS(N), .COORD_W(CW), .TICK_BASE(16), .SPEED_LEVELS(SL),
    .SCORE_W(SW), .WIN_SCORE(2), .FLASH_CYCLES(8), .FLASH_TOGGLE(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .speed_sel(speed_sel),
    .head_x(head_x), .head_y(head_y),
    .hit_wall(hit_wall), .hit_body(hit_body), .hit_other(hit_other),
    .step(step), .alive(alive), .game_status(game_status),
    .die_flash(die_flash), .score(score), .winner(winner),
    .over(over), .speed_light(speed_light)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pop an expectation every time the DUT strobes step.
  always @(negedge clk) begin
    if (rst && step != '0) begin
      if (exp_cyc.size() == 0) begin
        check("step_unexpected", {30'd0, step}, 32'd0);
      end else begin
        automatic int         c = exp_cyc.pop_front();
        automatic logic [1:0] v = exp_val.pop_front();
        check("step_cycle", cyc, c);
        check("step_value", {30'd0, step}, {30'd0, v});
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_step(input int c, input logic [1:0] v);
    exp_cyc.push_back(c);
    exp_val.push_back(v);
  endtask

  // Pulse start and run n full step periods of the given length.
  task automatic start_round(input int period, input int n);
    int c0;
    c0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= n; k++) push_step(c0 + 1 + period * k, 2'b11);
    repeat (period * n) @(posedge clk);
    #1;
  endtask

  // Called with the killing inputs already driven; walks the whole FLASH phase.
  task automatic check_flash(input logic [1:0] exp_alive, input logic [7:0] exp_score,
                             input bit poke_start);
    @(posedge clk); #1;
    hit_wall = '0; hit_body = '0; hit_other = '0;
    head_x = {6'd1, 6'd0}; head_y = {6'd5, 6'd5};
    check("death_alive", {30'd0, alive}, {30'd0, exp_alive});
    check("death_score", {24'd0, score}, {24'd0, exp_score});
    for (int f = 0; f < 8; f++) begin
      check("flash_status", {30'd0, game_status}, 32'd2);
      check("flash_blink", {31'd0, die_flash}, ((f / 2) % 2 == 0) ? 32'd1 : 32'd0);
      start = (poke_start && f == 3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("flash_off", {31'd0, die_flash}, 32'd0);
  endtask

  initial begin
    int c0;
    rst = 1'b0; start = 1'b0; speed_sel = 2'd0;
    head_x = {6'd1, 6'd0}; head_y = {6'd5, 6'd5};
    hit_wall = '0; hit_body = '0; hit_other = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", {30'd0, game_status}, 32'd0);
    check("rst_alive", {30'd0, alive}, 32'd3);
    check("rst_light", {28'd0, speed_light}, 32'd1);
    check("rst_score", {24'd0, score}, 32'd0);
    check("rst_flash", {31'd0, die_flash}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Speed 0 (period 16), then speed 2 requested mid-period.
    c0 = cyc;
    for (int k = 1; k <= 4; k++) push_step(c0 + 1 + 16 * k, 2'b11);
    for (int k = 1; k <= 3; k++) push_step(c0 + 65 + 4 * k, 2'b11);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_status", {30'd0, game_status}, 32'd1);
    wait_cyc(c0 + 54);
    speed_sel = 2'd2;
    check("light_old", {28'd0, speed_light}, 32'd1);
    wait_cyc(c0 + 66);
    check("light_new", {28'd0, speed_light}, 32'd4);
    wait_cyc(c0 + 78);

    // Player 1 hits the wall; start during FLASH must be ignored.
    hit_wall = 2'b10;
    check_flash(2'b01, 8'h01, 1'b1);
    check("idle_status", {30'd0, game_status}, 32'd0);
    check("idle_alive", {30'd0, alive}, 32'd3);

    // Head-to-head at (10,10): draw.
    speed_sel = 2'd3;
    start_round(2, 2);
    head_x = {6'd10, 6'd10}; head_y = {6'd10, 6'd10};
    check_flash(2'b00, 8'h01, 1'b0);
    check("draw_idle", {30'd0, game_status}, 32'd0);

    // Player 0 wins again through player 1's cross-body hit: match over.
    start_round(2, 1);
    hit_other = 2'b10;
    check_flash(2'b01, 8'h02, 1'b0);
    check("over_status", {30'd0, game_status}, 32'd3);
    check("over_flag", {31'd0, over}, 32'd1);
    check("over_winner", {30'd0, winner}, 32'd1);

    // New match from OVER.
    start_round(2, 1);
    check("new_status", {30'd0, game_status}, 32'd1);
    check("new_score", {24'd0, score}, 32'd0);
    check("new_over", {31'd0, over}, 32'd0);
    check("new_winner", {30'd0, winner}, 32'd0);
    check("new_alive", {30'd0, alive}, 32'd3);
    check("new_light", {28'd0, speed_light}, 32'd8);

    // Player 0 self-hits; asynchronous reset in the middle of FLASH.
    hit_body = 2'b01;
    @(posedge clk); #1;
    hit_body = '0;
    check("p1_alive", {30'd0, alive}, 32'd2);
    check("p1_score", {24'd0, score}, 32'h10);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_status", {30'd0, game_status}, 32'd0);
    check("arst_alive", {30'd0, alive}, 32'd3);
    check("arst_score", {24'd0, score}, 32'd0);
    check("arst_flash", {31'd0, die_flash}, 32'd0);
    check("arst_light", {28'd0, speed_light}, 32'd1);
    check("arst_over", {31'd0, over}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_round(2, 2);
    check("fresh_status", {30'd0, game_status}, 32'd1);
    @(posedge clk); #1;

    check("step_missing", exp_cyc.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/snake_match_ctrl.md
Name: snake_match_ctrl

Overview:
- Parametrised match controller for N-player snake. It generalises the fixed two-player speed control, per-player hit flags and game-over counter into one block.
- Generates per-player step ticks at a selectable speed and detects wall, self, cross-body and head-to-head deaths.
- Runs the round/match state machine and keeps per-player scores with winner detection.
- Sits between the key/speed inputs, the snake position engines and the VGA/seven-segment outputs.

Parameters:
N_PLAYERS, 2, number of snakes (1..4)
COORD_W, 6, width of one head coordinate
TICK_BASE, 12500000, clock cycles per step at speed level 0 (slowest)
SPEED_LEVELS, 4, number of speed levels; level k period = TICK_BASE >> k
SCORE_W, 4, per-player score width
WIN_SCORE, 5, score that ends the match
FLASH_CYCLES, 50000000, length of the death-flash phase
FLASH_TOGGLE, 6250000, die_flash half-period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a round or a new match
speed_sel  in  clog2(SPEED_LEVELS)  requested speed level
head_x  in  N_PLAYERS*COORD_W  packed head x, player 0 in the LSBs
head_y  in  N_PLAYERS*COORD_W  packed head y
hit_wall  in  N_PLAYERS  per-player wall collision, level
hit_body  in  N_PLAYERS  per-player self-body collision, level
hit_other  in  N_PLAYERS  player head inside another snake's body, level
step  out  N_PLAYERS  one-cycle move strobe per alive player
alive  out  N_PLAYERS  player still in the round
game_status  out  2  00 IDLE, 01 RUN, 10 FLASH, 11 OVER
die_flash  out  1  blink signal for the renderer
score  out  N_PLAYERS*SCORE_W  packed scores
winner  out  N_PLAYERS  one-hot match winner, valid in OVER
over  out  1  high in OVER
speed_light  out  SPEED_LEVELS  one-hot active speed level

Behaviour:
- Reset (rst=0, async):
  - state IDLE; step=0; alive=all ones; die_flash=0; score=0; winner=0; over=0.
  - Active speed level = 0, so speed_light=1.
  - Tick counter = 0; flash counters = 0.
- Speed handling:
  - Tick counter runs only in RUN. It counts 0..P-1, where P = TICK_BASE >> active level.
  - At count P-1, step = alive for exactly one cycle and the counter wraps to 0.
  - speed_sel is latched into the active level only on the wrap cycle, or on entry to RUN. This prevents mid-period glitches when the speed switches change.
  - Out-of-range speed_sel saturates to SPEED_LEVELS-1.
  - speed_light reflects the active level, not speed_sel.
- Death detection:
  - Evaluated every cycle in RUN, for alive players only.
  - Player i dies when hit_wall[i] | hit_body[i] | hit_other[i] is high.
  - Player i also dies when its head equals the head of any other alive player j (head-to-head); in that case both die.
  - All deaths found in the same cycle are applied together; alive bits clear on the next edge.
  - Inputs for dead players are ignored.
- State machine:
  - IDLE -> RUN on start. Tick counter is cleared and alive is set to all ones.
  - RUN -> FLASH when popcount(alive after update) <= (N_PLAYERS>1 ? 1 : 0).
    - A sole survivor's score increments by 1, saturating at 2^SCORE_W-1.
    - If every remaining player dies in the same cycle, it is a draw and no score changes.
    - step is forced to 0 from the transition cycle onward.
  - FLASH lasts FLASH_CYCLES. die_flash toggles every FLASH_TOGGLE cycles starting high, and is 0 outside FLASH.
    - At the end of FLASH: if any score >= WIN_SCORE, or N_PLAYERS=1, go to OVER. Otherwise go to IDLE with alive=all ones.
  - OVER: over=1 and winner = one-hot of the player with score >= WIN_SCORE (lowest index if several; 0 when N_PLAYERS=1).
    - start clears scores and winner, sets alive=all ones, and goes directly to RUN.
- start is ignored in RUN and FLASH.
- Reset mid-round returns to IDLE immediately and does not preserve scores.

Test Plan:
1. Sim params N=2, TICK_BASE=16, FLASH_CYCLES=8, FLASH_TOGGLE=2, WIN_SCORE=2 -> reset: game_status=00, alive=2'b11, speed_light=4'b0001; start -> step=2'b11 pulses every 16 cycles.
2. In RUN, speed_sel changes 0->2 at counter 5 -> the current period completes at 16 cycles, subsequent periods are 4 cycles, speed_light=4'b0100.
3. hit_wall[1]=1 for one cycle -> alive=2'b01, score0=1, game_status=10, die_flash high 2 cycles/low 2 cycles for 8 cycles, then IDLE with alive=2'b11.
4. Heads both at (10,10) in the same cycle -> alive=00, scores unchanged (draw), FLASH then IDLE.
5. Player 0 wins two rounds -> after second FLASH game_status=11, over=1, winner=2'b01; start -> scores=0, RUN.
6. Assert rst low during FLASH -> all outputs return to reset values asynchronously; start afterwards begins a fresh round.
